aes_encipher_block: RTL



---
 rtl/aes_encipher_block.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 block encipher: one round per clock, with round keys
// fetched combinationally from an external key memory via round/round_key.

module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? aa : 8'h00);
            aa  = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Inverse as x^254 (square-and-multiply), followed by the affine transform.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Pure combinational substitution of one byte.
    always_comb begin
        result = sbox_f(value);
    end
endmodule

module aes_encipher_block #(
    parameter logic [3:0] AES128_ROUNDS = 4'd10,
    parameter logic [3:0] AES256_ROUNDS = 4'd14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    typedef enum logic [1:0] {IDLE, INIT, MAIN, FINAL} fsm_t;

    fsm_t         fsm_r;
    logic [127:0] state_r;
    logic [3:0]   nr_r;
    logic [3:0]   counter_r;
    logic         ready_r;
    logic [127:0] sub_s;
    logic [127:0] shift_s;
    logic [127:0] mix_s;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_sbox u_sbox (
            .value  (state_r[8*g +: 8]),
            .result (sub_s[8*g +: 8])
        );
    end

    // Byte (row r, col c) sits at bits [127-8*(4c+r) -: 8]; row r rotates left by r.
    always_comb begin
        shift_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_s[127 - 8*(4*c + r) -: 8] = sub_s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
    end

    // Columns are contiguous 32-bit slices with row 0 in the top byte.
    always_comb begin
        mix_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            mix_s[127 - 32*c -: 32] = mix_column(shift_s[127 - 32*c -: 32]);
        end
    end

    // Round sequencer; the counter doubles as the key-memory round index.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r     <= IDLE;
            state_r   <= 128'h0;
            nr_r      <= AES128_ROUNDS;
            counter_r <= 4'd0;
            ready_r   <= 1'b1;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (next) begin
                        state_r   <= block;
                        nr_r      <= keylen ? AES256_ROUNDS : AES128_ROUNDS;
                        counter_r <= 4'd0;
                        ready_r   <= 1'b0;
                        fsm_r     <= INIT;
                    end else begin
                        fsm_r <= IDLE;
                    end
                end
                INIT: begin
                    state_r   <= state_r ^ round_key;
                    counter_r <= 4'd1;
                    fsm_r     <= MAIN;
                end
                MAIN: begin
                    state_r   <= mix_s ^ round_key;
                    counter_r <= counter_r + 4'd1;
                    if (counter_r == nr_r - 4'd1) begin
                        fsm_r <= FINAL;
                    end else begin
                        fsm_r <= MAIN;
                    end
                end
                FINAL: begin
                    state_r   <= shift_s ^ round_key;
                    counter_r <= 4'd0;
                    ready_r   <= 1'b1;
                    fsm_r     <= IDLE;
                end
                default: begin
                    counter_r <= 4'd0;
                    ready_r   <= 1'b1;
                    fsm_r     <= IDLE;
                end
            endcase
        end
    end

    assign round     = counter_r;
    assign new_block = state_r;
    assign ready     = ready_r;
endmodule
